// File: rtl/fixed_div_seq.sv
// Sequential signed fixed-point divider (radix-2 restoring, one quotient bit per cycle).
// Define DIV_ROUND_EN for round-half-away-from-zero via one extra guard iteration.
module fixed_div_seq #(
  parameter int WIDTH   = 16,
  parameter int FRAC_SZ = 12,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic             dbz,
  output logic             ovf
);

  localparam int N = WIDTH + FRAC_SZ;
`ifdef DIV_ROUND_EN
  localparam int ITER = N + 1;
`else
  localparam int ITER = N;
`endif
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int QW    = N + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [ITER-1:0]  sr_reg;       // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] den_mag_reg;
  logic             neg_reg;
  logic             in_ready_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic             accept;
  logic             den_zero;
  logic             last_iter;
  logic [WIDTH-1:0] num_mag;
  logic [WIDTH-1:0] den_mag;
  logic [WIDTH-1:0] dbz_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [ITER-1:0]  sr_shift;
  logic [QW-1:0]    q_mag;
  logic [WIDTH-1:0] sat_q;
  logic             sat_ovf;

  assign accept    = in_valid && in_ready_reg && (state_reg == IDLE);
  assign den_zero  = (denominator == '0);
  assign last_iter = (cnt_reg == CNT_W'(1));
  // Magnitudes kept in WIDTH bits so the most negative value is represented exactly.
  assign num_mag   = numerator[WIDTH-1]   ? -numerator   : numerator;
  assign den_mag   = denominator[WIDTH-1] ? -denominator : denominator;
  assign dbz_q     = numerator[WIDTH-1] ? MAX_NEG : ((numerator == '0) ? '0 : MAX_POS);

  assign shifted  = {rem_reg, sr_reg[ITER-1]};
  assign qbit     = (shifted >= {1'b0, den_mag_reg});
  assign diff     = shifted[WIDTH-1:0] - den_mag_reg;
  assign rem_next = qbit ? diff : shifted[WIDTH-1:0];
  assign sr_shift = {sr_reg[ITER-2:0], qbit};

`ifdef DIV_ROUND_EN
  assign q_mag = QW'(sr_shift >> 1) + QW'(sr_shift[0]);
`else
  assign q_mag = QW'(sr_shift);
`endif

  always_comb begin
    sat_q   = q_mag[WIDTH-1:0];
    sat_ovf = 1'b0;
    if (!neg_reg) begin
      if (q_mag > QW'(MAX_POS)) begin
        sat_q   = MAX_POS;
        sat_ovf = 1'b1;
      end
    end else begin
      if (q_mag > QW'(MAX_NEG)) begin
        sat_q   = MAX_NEG;
        sat_ovf = 1'b1;
      end else begin
        sat_q = -q_mag[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = den_zero ? DONE : BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= '0;
      sr_reg       <= '0;
      rem_reg      <= '0;
      den_mag_reg  <= '0;
      neg_reg      <= 1'b0;
      in_ready_reg <= 1'b0;
      quotient_reg <= '0;
      out_tag_reg  <= '0;
      dbz_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            den_mag_reg <= den_mag;
            neg_reg     <= numerator[WIDTH-1] ^ denominator[WIDTH-1];
            sr_reg      <= {num_mag, {(ITER-WIDTH){1'b0}}};
            rem_reg     <= '0;
            cnt_reg     <= CNT_W'(ITER);
            out_tag_reg <= in_tag;
            ovf_reg     <= 1'b0;
            dbz_reg     <= den_zero;
            if (den_zero) quotient_reg <= dbz_q;
          end
        end
        BUSY: begin
          sr_reg  <= sr_shift;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (last_iter) begin
            quotient_reg <= sat_q;
            ovf_reg      <= sat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign out_tag   = out_tag_reg;
  assign dbz       = dbz_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Randomised and directed bench for fixed_div_seq against an arithmetic reference model.
// Honours DIV_ROUND_EN the same way the design does.
module tb_fixed_div_seq;

  localparam int WIDTH   = 16;
  localparam int FRAC_SZ = 12;
  localparam int TAG_W   = 4;
  localparam int N       = WIDTH + FRAC_SZ;
`ifdef DIV_ROUND_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif
  localparam longint MAXV = 32767;
  localparam longint MINMAG = 32768;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] numerator;
  logic signed [WIDTH-1:0] denominator;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] quotient;
  logic [TAG_W-1:0]        out_tag;
  logic                    dbz;
  logic                    ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fixed_div_seq #(.WIDTH(WIDTH), .FRAC_SZ(FRAC_SZ), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .numerator(numerator), .denominator(denominator), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .out_tag(out_tag), .dbz(dbz), .ovf(ovf)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Quotient = num * 2^FRAC_SZ / den, then saturated to the signed range.
  function automatic void model(input longint n, input longint d,
                                output longint q, output longint ez, output longint eo);
    longint a, b, m;
    bit neg;
    ez = 0; eo = 0;
    if (d == 0) begin
      ez = 1;
      q = (n > 0) ? MAXV : ((n < 0) ? -MINMAG : 0);
      return;
    end
    a = ((n < 0) ? -n : n) * (64'sd1 << FRAC_SZ);
    b = (d < 0) ? -d : d;
`ifdef DIV_ROUND_EN
    m = (2 * a + b) / (2 * b);
`else
    m = a / b;
`endif
    neg = (n < 0) != (d < 0);
    if (!neg) begin
      if (m > MAXV) begin q = MAXV; eo = 1; end
      else q = m;
    end else begin
      if (m > MINMAG) begin q = -MINMAG; eo = 1; end
      else q = -m;
    end
  endfunction

  task automatic start_op(input longint n, input longint d, input logic [TAG_W-1:0] t);
    int k = 0;
    while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!in_ready) check("accept_timeout", 0, 1);
    numerator = WIDTH'(n); denominator = WIDTH'(d); in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    numerator = WIDTH'($urandom); denominator = WIDTH'($urandom); in_tag = TAG_W'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic check_result(input string nm, input longint n, input longint d,
                              input logic [TAG_W-1:0] t, input int lat);
    longint q, ez, eo;
    model(n, d, q, ez, eo);
    check({nm, "_valid"}, longint'(out_valid), 1);
    check({nm, "_lat"}, lat, (d == 0) ? 1 : LAT);
    check({nm, "_q"}, longint'(quotient), q);
    check({nm, "_tag"}, longint'(out_tag), longint'(t));
    check({nm, "_dbz"}, longint'(dbz), ez);
    check({nm, "_ovf"}, longint'(ovf), eo);
    $display("op %s: %0d / %0d tag %0d -> q %0d dbz %0d ovf %0d lat %0d",
             nm, n, d, t, quotient, dbz, ovf, lat);
  endtask

  task automatic handshake(input string nm);
    @(posedge clk); #1;
    check({nm, "_hs_valid"}, longint'(out_valid), 0);
    check({nm, "_hs_ready"}, longint'(in_ready), 1);
  endtask

  task automatic do_op(input string nm, input longint n, input longint d);
    logic [TAG_W-1:0] t;
    int lat;
    t = TAG_W'($urandom);
    start_op(n, d, t);
    wait_valid(lat);
    check_result(nm, n, d, t, lat);
    handshake(nm);
  endtask

  longint dir_n [14] = '{4096, 2048, -4096, 6144, 0, 4096, -4096, 0,
                         32767, -32768, -32768, 8192, -8192, 1};
  longint dir_d [14] = '{2048, 4096, 2048, 2048, 2048, 0, 0, 0,
                         1, 4096, -4096, 12288, 12288, -3};

  initial begin
    longint bq;
    logic [TAG_W-1:0] btag, t2;
    int lat;
    longint rn, rd;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    numerator = '0; denominator = '0; in_tag = '0;
    #1;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_q", longint'(quotient), 0);
    check("rst_tag", longint'(out_tag), 0);
    check("rst_dbz", longint'(dbz), 0);
    check("rst_ovf", longint'(ovf), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", longint'(in_ready), 1);

    for (int i = 0; i < 14; i++) do_op($sformatf("dir%0d", i), dir_n[i], dir_d[i]);

    // Backpressure with a second request waiting.
    out_ready = 1'b0;
    btag = 4'd5;
    start_op(4096, 2048, btag);
    wait_valid(lat);
    check_result("bp", 4096, 2048, btag, lat);
    bq = longint'(quotient);
    t2 = 4'd9;
    numerator = 16'sd2048; denominator = 16'sd4096; in_tag = t2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", longint'(out_valid), 1);
      check("bp_hold_q", longint'(quotient), bq);
      check("bp_hold_tag", longint'(out_tag), longint'(btag));
      check("bp_hold_dbz", longint'(dbz), 0);
      check("bp_hold_ovf", longint'(ovf), 0);
      check("bp_hold_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    handshake("bp");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check_result("bp2", 2048, 4096, t2, lat);
    handshake("bp2");

    // Asynchronous reset during BUSY discards the operation.
    start_op(3000, 7, 4'd3);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_q", longint'(quotient), 0);
    check("mid_rst_dbz", longint'(dbz), 0);
    check("mid_rst_ovf", longint'(ovf), 0);
    check("mid_rst_ready", longint'(in_ready), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_ready", longint'(in_ready), 1);
    do_op("post_rst", 6144, 2048);

    for (int i = 0; i < 150; i++) begin
      rn = longint'($signed(16'($urandom)));
      case ($urandom_range(0, 9))
        0:       rd = 0;
        1:       rd = longint'($urandom_range(1, 16)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
        2:       rd = -32768;
        default: rd = longint'($signed(16'($urandom)));
      endcase
      if ($urandom_range(0, 15) == 0) rn = -32768;
      do_op($sformatf("rnd%0d", i), rn, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
